rd_data_checker: RTL and testbench
==================================

// Module: rd_data_checker
// PURPOSE
//  Read-data checker in the rd_clk domain, downstream of the DDR2 read-data FIFO.
//  Consumes every FIFO output word: the FIFO pops whenever not empty and takes no backpressure.
//  Compares each word against the incrementing pattern written by the write-side generator.
//  Reports error count, completed bursts and pass/fail for the on-board DDR2 test.
// PARAMETERS
//  DATA_WIDTH   128  read word width; multiple of 32
//  WRITE_BURST  8    words per burst; power of two, >=2
//  BURST_NUM_W  16   width of burst_num / burst_cnt
//  ERR_CNT_W    16   width of err_cnt (saturating)
// PORTS
//  rd_clk        in   1            sole clock
//  reset_n       in   1            asynchronous, active-low reset
//  start         in   1            1-cycle pulse: arm a new check run
//  abort         in   1            1-cycle pulse: end the run now, fail
//  seed          in   32           first expected pattern value, sampled on start
//  burst_num     in   BURST_NUM_W  bursts to check, sampled on start
//  rd_fifo_out   in   DATA_WIDTH   read word from the read FIFO
//  fifo_out_vd   in   1            rd_fifo_out valid; always accepted
//  busy          out  1            high in CHECK
//  done          out  1            1-cycle pulse on entry to DONE
//  pass          out  1            result; valid from done until next start
//  err_cnt       out  ERR_CNT_W    mismatching words this run; saturates at all-ones
//  burst_cnt     out  BURST_NUM_W  completed bursts this run
//  unexpected    out  1            sticky: fifo_out_vd seen outside CHECK; cleared by start
//  first_err_vld out  1            first-error capture valid (see CONFIGURATION)
//  first_err_idx out  32           word index within run of first mismatch
//  first_err_dat out  DATA_WIDTH   received data of first mismatch
// BEHAVIOUR
//  - Reset: state=IDLE; busy, done, pass, unexpected, first_err_vld = 0; all counters and data = 0.
//  - Expected word = {DATA_WIDTH/32 copies of exp[31:0]}; exp wraps modulo 2^32.
//  - States:
//    - IDLE:  start -> CHECK.
//    - CHECK: each beat compares and advances; final beat or abort -> DONE.
//    - DONE:  holds results; start -> CHECK.
//  - start in IDLE/DONE:
//    - load exp=seed, target=burst_num; clear beat, burst_cnt, err_cnt, word index, unexpected, first_err_*.
//    - pass=0; enter CHECK next cycle.
//  - start while in CHECK: ignored.
//  - burst_num==0 on start: enter DONE directly; done pulses the cycle after start; pass=1.
//  - CHECK, fifo_out_vd=1: compare rd_fifo_out to expected.
//    - Mismatch: err_cnt++ (saturating).
//    - Always: exp++, index++, beat++.
//    - beat==WRITE_BURST-1: beat wraps to 0, burst_cnt++.
//  - Final beat (burst_cnt+1==target):
//    - Next cycle: state=DONE, done=1 for one cycle.
//    - pass = (no mismatch this run, including the final word).
//    - Latency: done one cycle after final valid beat; err_cnt/burst_cnt registered, updated the cycle after the beat.
//  - abort in CHECK: DONE next cycle, done pulse, pass=0; a coincident vd beat is still counted.
//  - abort in IDLE/DONE: ignored.
//  - start and abort in the same cycle: start wins in IDLE/DONE; abort wins in CHECK.
//  - fifo_out_vd in IDLE/DONE: data ignored, counters unchanged, unexpected=1.
//  - Reset assertion mid-run: immediate return to reset values; no done pulse.
// CONFIGURATION
//  - RD_CHK_FIRST_ERR_EN defined:
//    - On the first mismatch of a run, latch index and received data; set first_err_vld.
//    - Later mismatches do not overwrite; cleared by start.
//  - Not defined: first_err_vld, first_err_idx, first_err_dat tied to 0; no capture registers.
// TESTING
//  1 seed=0x0, burst_num=4, 32 clean consecutive words
//    -> done 1 cycle after word 31, pass=1, err_cnt=0, burst_cnt=4.
//  2 seed=0xFFFFFFFE, burst_num=1, 8 clean words with gaps of 0-3 idle cycles
//    -> exp wraps 0xFFFFFFFF->0x0, pass=1.
//  3 seed=0x100, burst_num=2, word 5 bit 77 flipped, word 12 corrupt
//    -> err_cnt=2, pass=0.
//    -> with macro: first_err_idx=5, first_err_dat=received word 5.
//  4 burst_num=2, abort after 9 words -> done next cycle, pass=0, burst_cnt=1.
//    -> start asserted in CHECK mid-run: ignored, counters continue.
//  5 fifo_out_vd pulses in IDLE -> unexpected=1; next start clears it.
//    -> burst_num=0 start -> done next cycle, pass=1.
//  6 reset_n low mid-run after 10 words -> all outputs 0 asynchronously, state IDLE, no done.

Source files
------------

// File: rtl/rd_data_checker.sv
// Read-data checker: compares every DDR2 read-FIFO word against an incrementing 32-bit pattern; 1-cycle latency to done, no backpressure.
// Optional first-mismatch capture enabled by RD_CHK_FIRST_ERR_EN; without it first_err_* outputs are tied to 0.
module rd_data_checker #(
  parameter int DATA_WIDTH  = 128,
  parameter int WRITE_BURST = 8,
  parameter int BURST_NUM_W = 16,
  parameter int ERR_CNT_W   = 16
) (
  input  logic                   rd_clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic [31:0]            seed,
  input  logic [BURST_NUM_W-1:0] burst_num,
  input  logic [DATA_WIDTH-1:0]  rd_fifo_out,
  input  logic                   fifo_out_vd,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [ERR_CNT_W-1:0]   err_cnt,
  output logic [BURST_NUM_W-1:0] burst_cnt,
  output logic                   unexpected,
  output logic                   first_err_vld,
  output logic [31:0]            first_err_idx,
  output logic [DATA_WIDTH-1:0]  first_err_dat
);

  localparam int LANES  = DATA_WIDTH / 32;
  localparam int BEAT_W = (WRITE_BURST > 1) ? $clog2(WRITE_BURST) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CHECK = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]             state_q, state_d;
  logic [31:0]            exp_q, exp_d;
  logic [BURST_NUM_W-1:0] target_q, target_d;
  logic [BEAT_W-1:0]      beat_q, beat_d;
  logic [BURST_NUM_W-1:0] burst_cnt_q, burst_cnt_d;
  logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;
  logic                   unexpected_q, unexpected_d;
  logic                   done_q, done_d;
  logic                   pass_q, pass_d;

  logic [DATA_WIDTH-1:0]  exp_word;
  logic                   start_load;
  logic                   beat_vld;
  logic                   mismatch;
  logic                   last_beat;
  logic                   final_beat;
  logic [BURST_NUM_W-1:0] burst_inc;
  logic [ERR_CNT_W-1:0]   err_inc;

  always_comb begin
    exp_word   = {LANES{exp_q}};
    start_load = start && (state_q != ST_CHECK);
    beat_vld   = fifo_out_vd && (state_q == ST_CHECK);
    mismatch   = beat_vld && (rd_fifo_out != exp_word);
    last_beat  = (beat_q == BEAT_W'(WRITE_BURST - 1));
    burst_inc  = burst_cnt_q + BURST_NUM_W'(1);
    final_beat = beat_vld && last_beat && (burst_inc == target_q);
    err_inc    = (err_cnt_q == '1) ? err_cnt_q : err_cnt_q + ERR_CNT_W'(1);
  end

  always_comb begin
    state_d      = state_q;
    exp_d        = exp_q;
    target_d     = target_q;
    beat_d       = beat_q;
    burst_cnt_d  = burst_cnt_q;
    err_cnt_d    = err_cnt_q;
    unexpected_d = unexpected_q;
    done_d       = 1'b0;
    pass_d       = pass_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_load) begin
          exp_d        = seed;
          target_d     = burst_num;
          beat_d       = '0;
          burst_cnt_d  = '0;
          err_cnt_d    = '0;
          unexpected_d = 1'b0;
          // An empty run has nothing to check, so it completes immediately as a pass.
          if (burst_num == '0) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            pass_d  = 1'b1;
          end else begin
            state_d = ST_CHECK;
            pass_d  = 1'b0;
          end
        end else if (fifo_out_vd) begin
          unexpected_d = 1'b1;
        end
      end

      ST_CHECK: begin
        if (beat_vld) begin
          exp_d = exp_q + 32'd1;
          if (mismatch) begin
            err_cnt_d = err_inc;
          end
          if (last_beat) begin
            beat_d      = '0;
            burst_cnt_d = burst_inc;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
        // Abort has priority over a coincident final beat; the beat itself is still counted above.
        if (abort) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          pass_d  = 1'b0;
        end else if (final_beat) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          pass_d  = (err_cnt_q == '0) && !mismatch;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge rd_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      exp_q        <= '0;
      target_q     <= '0;
      beat_q       <= '0;
      burst_cnt_q  <= '0;
      err_cnt_q    <= '0;
      unexpected_q <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      exp_q        <= exp_d;
      target_q     <= target_d;
      beat_q       <= beat_d;
      burst_cnt_q  <= burst_cnt_d;
      err_cnt_q    <= err_cnt_d;
      unexpected_q <= unexpected_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
    end
  end

  assign busy       = (state_q == ST_CHECK);
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_cnt    = err_cnt_q;
  assign burst_cnt  = burst_cnt_q;
  assign unexpected = unexpected_q;

`ifdef RD_CHK_FIRST_ERR_EN
  logic [31:0]           idx_q, idx_d;
  logic                  fe_vld_q, fe_vld_d;
  logic [31:0]           fe_idx_q, fe_idx_d;
  logic [DATA_WIDTH-1:0] fe_dat_q, fe_dat_d;

  always_comb begin
    idx_d    = idx_q;
    fe_vld_d = fe_vld_q;
    fe_idx_d = fe_idx_q;
    fe_dat_d = fe_dat_q;
    if (start_load) begin
      idx_d    = '0;
      fe_vld_d = 1'b0;
      fe_idx_d = '0;
      fe_dat_d = '0;
    end else begin
      if (beat_vld) begin
        idx_d = idx_q + 32'd1;
      end
      if (mismatch && !fe_vld_q) begin
        fe_vld_d = 1'b1;
        fe_idx_d = idx_q;
        fe_dat_d = rd_fifo_out;
      end
    end
  end

  always_ff @(posedge rd_clk or negedge reset_n) begin
    if (!reset_n) begin
      idx_q    <= '0;
      fe_vld_q <= 1'b0;
      fe_idx_q <= '0;
      fe_dat_q <= '0;
    end else begin
      idx_q    <= idx_d;
      fe_vld_q <= fe_vld_d;
      fe_idx_q <= fe_idx_d;
      fe_dat_q <= fe_dat_d;
    end
  end

  assign first_err_vld = fe_vld_q;
  assign first_err_idx = fe_idx_q;
  assign first_err_dat = fe_dat_q;
`else
  assign first_err_vld = 1'b0;
  assign first_err_idx = '0;
  assign first_err_dat = '0;
`endif

endmodule

// File: tb/tb_rd_data_checker.sv
// Bench for rd_data_checker: random and directed runs scored against a run-level model; a monitor checks every done pulse.
module tb_rd_data_checker;
  localparam int DW  = 128;
  localparam int WB  = 8;
  localparam int BNW = 16;
  localparam int ECW = 16;

  logic           rd_clk = 1'b0;
  logic           reset_n = 1'b0;
  logic           start = 1'b0;
  logic           abort = 1'b0;
  logic [31:0]    seed = '0;
  logic [BNW-1:0] burst_num = '0;
  logic [DW-1:0]  rd_fifo_out = '0;
  logic           fifo_out_vd = 1'b0;
  logic           busy, done, pass, unexpected, first_err_vld;
  logic [ECW-1:0] err_cnt;
  logic [BNW-1:0] burst_cnt;
  logic [31:0]    first_err_idx;
  logic [DW-1:0]  first_err_dat;

  rd_data_checker #(.DATA_WIDTH(DW), .WRITE_BURST(WB), .BURST_NUM_W(BNW), .ERR_CNT_W(ECW)) dut (
    .rd_clk(rd_clk), .reset_n(reset_n), .start(start), .abort(abort), .seed(seed),
    .burst_num(burst_num), .rd_fifo_out(rd_fifo_out), .fifo_out_vd(fifo_out_vd),
    .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt), .burst_cnt(burst_cnt),
    .unexpected(unexpected), .first_err_vld(first_err_vld), .first_err_idx(first_err_idx),
    .first_err_dat(first_err_dat)
  );

  always #5 rd_clk = ~rd_clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge rd_clk) cyc <= cyc + 1;

  typedef struct {
    int            cyc;
    bit            pass;
    int            err;
    int            bursts;
    bit            fe_vld;
    int            fe_idx;
    logic [DW-1:0] fe_dat;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  // Run-level reference model state
  logic [31:0]   m_exp;
  int            m_words, m_bn, m_err, m_fe_idx;
  bit            m_fe, m_active;
  logic [DW-1:0] m_fe_dat;

  function automatic logic [DW-1:0] pat(input logic [31:0] v);
    return {(DW/32){v}};
  endfunction

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic push_result(input bit p);
    exp_t e;
    e.cyc = cyc + 1; e.pass = p; e.err = m_err; e.bursts = m_words / WB;
    e.fe_vld = m_fe; e.fe_idx = m_fe_idx; e.fe_dat = m_fe_dat;
    sb.push_back(e);
    m_active = 0;
  endtask

  task automatic tick();
    @(posedge rd_clk);
    #1;
  endtask

  task automatic start_run(input logic [31:0] s, input int bn, input bit with_abort);
    start = 1'b1; seed = s; burst_num = BNW'(bn); abort = with_abort;
    m_exp = s; m_words = 0; m_bn = bn; m_err = 0; m_fe = 0; m_fe_idx = 0; m_fe_dat = '0;
    m_active = 1;
    if (bn == 0) push_result(1'b1);
    tick();
    start = 1'b0; abort = 1'b0;
  endtask

  // One cycle of stimulus: optional data beat and/or abort.
  task automatic drive(input bit vd, input logic [DW-1:0] d, input bit ab);
    fifo_out_vd = vd; rd_fifo_out = d; abort = ab;
    if (m_active) begin
      if (vd) begin
        if (d !== pat(m_exp)) begin
          if (!m_fe) begin m_fe = 1; m_fe_idx = m_words; m_fe_dat = d; end
          if (m_err < (1 << ECW) - 1) m_err++;
        end
        m_exp = m_exp + 32'd1;
        m_words++;
      end
      if (ab) push_result(1'b0);
      else if (m_words == m_bn * WB) push_result(m_err == 0);
    end
    tick();
    fifo_out_vd = 1'b0; abort = 1'b0;
  endtask

  task automatic send_clean(input int n, input int max_gap);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, pat(m_exp), 1'b0);
      repeat ($urandom_range(0, max_gap)) tick();
    end
  endtask

  task automatic wait_drain(input string name);
    int k = 0;
    while (sb.size() != 0 && k < 50) begin tick(); k++; end
    check(name, sb.size(), 0);
  endtask

  always @(negedge rd_clk) begin
    if (reset_n && done) begin
      if (sb.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL spurious_done: got done=1 at cycle %0d expected no done", cyc);
      end else begin
        mon_e = sb.pop_front();
        check("done_cycle", cyc, mon_e.cyc);
        check("pass", pass, mon_e.pass);
        check("err_cnt", err_cnt, mon_e.err);
        check("burst_cnt", burst_cnt, mon_e.bursts);
        check("busy_at_done", busy, 0);
`ifdef RD_CHK_FIRST_ERR_EN
        check("first_err_vld", first_err_vld, mon_e.fe_vld);
        check("first_err_idx", first_err_idx, mon_e.fe_idx);
        check("first_err_dat", first_err_dat, mon_e.fe_dat);
`else
        check("first_err_vld", first_err_vld, 0);
        check("first_err_idx", first_err_idx, 0);
        check("first_err_dat", first_err_dat, 0);
`endif
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: got no end of test expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [DW-1:0] d;
    logic [DW-1:0] flip;
    int saved_err;
    m_active = 0;

    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_err", err_cnt, 0);
    check("rst_burst", burst_cnt, 0);
    check("rst_unexp", unexpected, 0);
    check("rst_fe_vld", first_err_vld, 0);
    reset_n = 1'b1;
    tick();

    // 1: 4 clean bursts back to back
    start_run(32'h0, 4, 1'b0);
    check("busy_in_check", busy, 1);
    send_clean(8, 0);
    check("burst_cnt_mid", burst_cnt, 1);
    send_clean(24, 0);
    wait_drain("drain_t1");

    // 2: pattern wraps through 0xFFFFFFFF with idle gaps
    start_run(32'hFFFF_FFFE, 1, 1'b0);
    send_clean(8, 3);
    wait_drain("drain_t2");

    // 3: two corrupted words
    start_run(32'h100, 2, 1'b0);
    for (int i = 0; i < 16; i++) begin
      d = pat(m_exp);
      if (i == 5) d[77] = ~d[77];
      if (i == 12) d = ~d;
      drive(1'b1, d, 1'b0);
    end
    check("t3_err_cnt", err_cnt, 2);
    wait_drain("drain_t3");

    // 4: abort after 9 words, with an ignored start mid-run
    start_run(32'h55, 2, 1'b0);
    send_clean(4, 0);
    start = 1'b1; seed = 32'hDEAD; burst_num = '0;
    tick();
    start = 1'b0;
    check("start_in_check_busy", busy, 1);
    send_clean(5, 0);
    check("t4_burst_mid", burst_cnt, 1);
    drive(1'b0, '0, 1'b1);
    wait_drain("drain_t4");

    // start and abort together outside CHECK: start wins
    start_run(32'h7777, 1, 1'b1);
    send_clean(8, 1);
    wait_drain("drain_start_abort");

    // 5: data seen while idle, then an empty run
    saved_err = int'(err_cnt);
    fifo_out_vd = 1'b1; rd_fifo_out = {4{$urandom()}};
    tick();
    fifo_out_vd = 1'b0;
    check("unexp_set", unexpected, 1);
    check("unexp_err_kept", err_cnt, saved_err);
    start_run(32'h1234, 0, 1'b0);
    check("unexp_cleared", unexpected, 0);
    wait_drain("drain_t5");

    // randomized runs with sparse single-bit corruption and gaps
    for (int r = 0; r < 8; r++) begin
      start_run($urandom(), $urandom_range(1, 3), 1'b0);
      while (m_active) begin
        d = pat(m_exp);
        if ($urandom_range(0, 5) == 0) begin
          flip = '0;
          flip[$urandom_range(0, DW-1)] = 1'b1;
          d = d ^ flip;
        end
        drive(1'b1, d, (r == 7) && (m_words == 11));
        repeat ($urandom_range(0, 2)) tick();
      end
      wait_drain("drain_rand");
    end

    // 6: reset mid-run
    start_run(32'hABC, 3, 1'b0);
    for (int i = 0; i < 10; i++) begin
      d = pat(m_exp);
      if (i == 2) d[3] = ~d[3];
      drive(1'b1, d, 1'b0);
    end
    check("pre_rst_err", err_cnt, 1);
    m_active = 0;
    #2 reset_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_err", err_cnt, 0);
    check("arst_burst", burst_cnt, 0);
    check("arst_pass", pass, 0);
    check("arst_fe_vld", first_err_vld, 0);
    repeat (2) tick();
    reset_n = 1'b1;
    fifo_out_vd = 1'b1; rd_fifo_out = pat(32'hABC);
    tick();
    fifo_out_vd = 1'b0;
    check("post_rst_idle_unexp", unexpected, 1);
    repeat (10) tick();
    check("queue_empty_end", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
